// File: rtl/sim_video_out.sv
// sim_video_out: video output stage for simulation tops.
//
// Expands a core's packed N-bit-per-channel colour to 8 bits per channel,
// registers colour and sync/blank on the pixel enable, and measures beam
// position and frame geometry so a C++ harness can grab whole frames.
//
// Ports:
//   clk_sys, reset (sync, active-high), ce_pix (pixel enable)
//   rgb_i [3*COLOR_BITS]      packed colour ({B,G,R} if RGB_ORDER_BGR else {R,G,B})
//   hs_i, vs_i, hb_i, vb_i    sync and blank from the core
//   VGA_R/G/B [8]             expanded colour, one pixel-enable of latency
//   VGA_HS/VS/HB/VB           registered sync and blank, same latency
//   pix_x, pix_y [POS_W]      beam position of the pixel on VGA_*
//   pix_valid                 VGA_* pixel is active and updated this clock
//   frame_done                one-clock strobe at the end of a complete frame
//   h_active, v_active        measured active width/height
//   frame_count [FCNT_W]      complete frames since reset
module sim_video_out #(
  parameter int COLOR_BITS    = 3,
  parameter int RGB_ORDER_BGR = 1,
  parameter int POS_W         = 11,
  parameter int FCNT_W        = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_pix,
  input  logic [3*COLOR_BITS-1:0] rgb_i,
  input  logic                    hs_i,
  input  logic                    vs_i,
  input  logic                    hb_i,
  input  logic                    vb_i,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_HB,
  output logic                    VGA_VB,
  output logic [POS_W-1:0]        pix_x,
  output logic [POS_W-1:0]        pix_y,
  output logic                    pix_valid,
  output logic                    frame_done,
  output logic [POS_W-1:0]        h_active,
  output logic [POS_W-1:0]        v_active,
  output logic [FCNT_W-1:0]       frame_count
);

  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [COLOR_BITS-1:0] r_c, g_c, b_c;
  logic [7:0]            r_x, g_x, b_x;

  if (RGB_ORDER_BGR != 0) begin : g_bgr
    assign {b_c, g_c, r_c} = rgb_i;
  end else begin : g_rgb
    assign {r_c, g_c, b_c} = rgb_i;
  end

  // MSB-first replication of the channel, truncated to 8 bits.
  for (genvar i = 0; i < 8; i++) begin : g_exp
    assign r_x[7-i] = r_c[COLOR_BITS-1-(i%COLOR_BITS)];
    assign g_x[7-i] = g_c[COLOR_BITS-1-(i%COLOR_BITS)];
    assign b_x[7-i] = b_c[COLOR_BITS-1-(i%COLOR_BITS)];
  end

  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [3:0]        sync_q, sync_d;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic [POS_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [POS_W-1:0]  h_q, h_d, v_q, v_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              pix_valid_q, pix_valid_d;
  logic              done_q, done_d;
  logic              hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d;
  logic              armed_q, armed_d;

  logic act, hb_rise, vb_rise, vb_fall;

  assign act     = ~hb_i & ~vb_i;
  assign hb_rise = hb_i & ~hb_prev_q;
  assign vb_rise = vb_i & ~vb_prev_q;
  assign vb_fall = ~vb_i & vb_prev_q;

  always_comb begin
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    sync_d      = sync_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    h_d         = h_q;
    v_d         = v_q;
    fcnt_d      = fcnt_q;
    hb_prev_d   = hb_prev_q;
    vb_prev_d   = vb_prev_q;
    armed_d     = armed_q;
    pix_valid_d = 1'b0;
    // The strobe drops on the very next clock, whether or not ce_pix is high.
    done_d      = 1'b0;

    if (ce_pix) begin
      r_d       = r_x;
      g_d       = g_x;
      b_d       = b_x;
      sync_d    = {hs_i, vs_i, hb_i, vb_i};
      hb_prev_d = hb_i;
      vb_prev_d = vb_i;

      if (act) begin
        pix_x_d     = x_q;
        pix_y_d     = y_q;
        pix_valid_d = 1'b1;
        if (x_q != POS_MAX) x_d = x_q + POS_W'(1);
      end

      // Line end is evaluated before frame end so that a line finishing in
      // the same sample as the frame is counted in v_active.
      if (hb_rise) begin
        if (x_q != '0) begin
          h_d = x_q;
          if (y_q != POS_MAX) y_d = y_q + POS_W'(1);
        end
        x_d = '0;
      end

      if (vb_fall) begin
        x_d     = '0;
        y_d     = '0;
        armed_d = 1'b1;
      end

      // Without a prior vb fall the frame began before reset: ignore it.
      if (vb_rise && armed_q) begin
        done_d = 1'b1;
        v_d    = y_d;
        fcnt_d = fcnt_q + FCNT_W'(1);
        y_d    = '0;
      end
    end
  end

  // ---- output / state register stage ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      sync_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      h_q         <= '0;
      v_q         <= '0;
      fcnt_q      <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      hb_prev_q   <= 1'b0;
      vb_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      sync_q      <= sync_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      h_q         <= h_d;
      v_q         <= v_d;
      fcnt_q      <= fcnt_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
      hb_prev_q   <= hb_prev_d;
      vb_prev_q   <= vb_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = sync_q[3];
  assign VGA_VS      = sync_q[2];
  assign VGA_HB      = sync_q[1];
  assign VGA_VB      = sync_q[0];
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = pix_valid_q;
  assign frame_done  = done_q;
  assign h_active    = h_q;
  assign v_active    = v_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_sim_video_out.sv
// Testbench for sim_video_out: three instances (3-bit BGR, 5-bit RGB,
// 8-bit BGR) share clock, enable and sync; expected outputs are queued when
// a pixel is driven and compared when it appears on the outputs.
module tb_sim_video_out;

  localparam int H_ACT    = 48;
  localparam int V_ACT    = 24;
  localparam int HB_LEN   = 4;
  localparam int VB_LINES = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [8:0]  rgb3 = '0;
  logic [14:0] rgb5 = '0;
  logic [23:0] rgb8 = '0;
  logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;

  logic [7:0]  r3, g3, b3;
  logic        vhs, vvs, vhb, vvb, pv, fd;
  logic [10:0] px, py, ha, va;
  logic [15:0] fc;

  logic [7:0]  r5, g5, b5, r8, g8, b8;
  logic        s5hs, s5vs, s5hb, s5vb, pv5, fd5;
  logic        s8hs, s8vs, s8hb, s8vb, pv8, fd8;
  logic [10:0] x5, y5, ha5, va5, x8, y8, ha8, va8;
  logic [15:0] fc5, fc8;

  always #5 clk = ~clk;

  sim_video_out #(.COLOR_BITS(3), .RGB_ORDER_BGR(1)) dut (
    .clk_sys(clk), .reset(reset), .ce_pix(ce), .rgb_i(rgb3),
    .hs_i(hs), .vs_i(vs), .hb_i(hb), .vb_i(vb),
    .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
    .VGA_HS(vhs), .VGA_VS(vvs), .VGA_HB(vhb), .VGA_VB(vvb),
    .pix_x(px), .pix_y(py), .pix_valid(pv), .frame_done(fd),
    .h_active(ha), .v_active(va), .frame_count(fc));

  sim_video_out #(.COLOR_BITS(5), .RGB_ORDER_BGR(0)) dut5 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce), .rgb_i(rgb5),
    .hs_i(hs), .vs_i(vs), .hb_i(hb), .vb_i(vb),
    .VGA_R(r5), .VGA_G(g5), .VGA_B(b5),
    .VGA_HS(s5hs), .VGA_VS(s5vs), .VGA_HB(s5hb), .VGA_VB(s5vb),
    .pix_x(x5), .pix_y(y5), .pix_valid(pv5), .frame_done(fd5),
    .h_active(ha5), .v_active(va5), .frame_count(fc5));

  sim_video_out #(.COLOR_BITS(8), .RGB_ORDER_BGR(1)) dut8 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce), .rgb_i(rgb8),
    .hs_i(hs), .vs_i(vs), .hb_i(hb), .vb_i(vb),
    .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
    .VGA_HS(s8hs), .VGA_VS(s8vs), .VGA_HB(s8hb), .VGA_VB(s8vb),
    .pix_x(x8), .pix_y(y8), .pix_valid(pv8), .frame_done(fd8),
    .h_active(ha8), .v_active(va8), .frame_count(fc8));

  typedef struct {
    logic [8:0] rgb;
    logic       hs, vs, hb, vb;
    logic [7:0] r, g, b;
  } vec_t;

  typedef struct {
    logic [7:0] r, g, b, r5, g5, b5, r8, g8, b8;
    logic [3:0] sync;
    logic       valid;
    int         x, y;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [7:0] e3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] e5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [127:0] outs();
    return 128'({r3, g3, b3, vhs, vvs, vhb, vvb, px, py, ha, va, fc});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
    total++;
    if (act === ex) passed++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, ex);
  endtask

  // One pixel: drive with ce high for one clock, compare, then one idle clock.
  task automatic sample(input logic [8:0] c3, input logic ihs, ivs, ihb, ivb,
                        input logic [7:0] er, eg, eb, input bit ev,
                        input int ex, input int ey, input bit ed);
    exp_t e;
    exp_t g;
    logic [127:0] snap;
    rgb3 = c3; hs = ihs; vs = ivs; hb = ihb; vb = ivb; ce = 1'b1;
    e.r = er; e.g = eg; e.b = eb;
    e.r5 = e5(rgb5[14:10]); e.g5 = e5(rgb5[9:5]); e.b5 = e5(rgb5[4:0]);
    e.r8 = rgb8[7:0]; e.g8 = rgb8[15:8]; e.b8 = rgb8[23:16];
    e.sync = {ihs, ivs, ihb, ivb};
    e.valid = ev; e.x = ex; e.y = ey; e.done = ed;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 128'(1), 128'(0));
    end else begin
      g = sbq.pop_front();
      chk("rgb3", 128'({r3, g3, b3}), 128'({g.r, g.g, g.b}));
      chk("rgb5", 128'({r5, g5, b5}), 128'({g.r5, g.g5, g.b5}));
      chk("rgb8", 128'({r8, g8, b8}), 128'({g.r8, g.g8, g.b8}));
      chk("sync", 128'({vhs, vvs, vhb, vvb}), 128'(g.sync));
      chk("pix_valid", 128'(pv), 128'(g.valid));
      if (g.valid) chk("pix_xy", 128'({px, py}), 128'({11'(g.x), 11'(g.y)}));
      chk("frame_done", 128'(fd), 128'(g.done));
    end
    ce = 1'b0;
    snap = outs();
    @(posedge clk); #1;
    chk("idle_valid", 128'(pv), 128'(0));
    chk("done_one_clk", 128'(fd), 128'(0));
    chk("idle_hold", outs(), snap);
  endtask

  task automatic stall(input int n);
    logic [127:0] snap;
    ce = 1'b0;
    snap = outs();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 128'(pv), 128'(0));
      chk("stall_hold", outs(), snap);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; rgb3 = '1; hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_outs", outs(), 128'(0));
    chk("reset_valid", 128'(pv), 128'(0));
    chk("reset_done", 128'(fd), 128'(0));
    reset = 1'b0; ce = 1'b0; hs = 1'b0; vs = 1'b0; hb = 1'b0; vb = 1'b0;
  endtask

  // A line is HB_LEN blanked samples followed by H_ACT pixel samples.
  task automatic run_line(input logic vb0, input logic vb1, input int y,
                          input int done_idx, input int stall_idx);
    for (int s = 0; s < HB_LEN + H_ACT; s++) begin
      logic h, v, a;
      logic [8:0] c;
      if (s == stall_idx) stall(10);
      h = (s < HB_LEN);
      v = (s == 0) ? vb0 : vb1;
      a = !h && !v;
      c = 9'($urandom);
      rgb5 = 15'($urandom);
      rgb8 = 24'($urandom);
      sample(c, (s == 1 || s == 2), v & h, h, v, e3(c[2:0]), e3(c[5:3]), e3(c[8:6]),
             a, s - HB_LEN, y, (s == done_idx));
    end
  endtask

  task automatic run_frame(input int nl, input bit armed, input bit simul,
                           input int rst_line, input int stall_line,
                           input int eh, input int ev, input int efc);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) do_reset();
      run_line(1'b0, 1'b0, (rst_line >= 0 && l >= rst_line) ? l - rst_line : l, -1,
               (l == stall_line) ? HB_LEN + 20 : -1);
    end
    run_line(simul, 1'b1, 0, armed ? (simul ? 0 : 1) : -1, -1);
    for (int k = 0; k < VB_LINES - 1; k++) run_line(1'b1, 1'b1, 0, -1, -1);
    chk("h_active", 128'(ha), 128'(eh));
    chk("v_active", 128'(va), 128'(ev));
    chk("frame_count", 128'(fc), 128'(efc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{9'b000_101_111, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hB6, 8'h00};
    tbl[1] = '{9'b111_000_001, 1'b1, 1'b0, 1'b0, 1'b1, 8'h24, 8'h00, 8'hFF};
    tbl[2] = '{9'b010_011_100, 1'b0, 1'b1, 1'b1, 1'b1, 8'h92, 8'h6D, 8'h49};
    tbl[3] = '{9'b110_001_010, 1'b1, 1'b1, 1'b1, 1'b1, 8'h49, 8'h24, 8'hDB};

    do_reset();

    for (int i = 0; i < 4; i++) begin
      rgb5 = 15'($urandom);
      rgb8 = 24'($urandom);
      sample(tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb,
             tbl[i].r, tbl[i].g, tbl[i].b, 1'b0, 0, 0, 1'b0);
    end

    // Channel sweep for the wider instances while blanked.
    for (int v = 0; v < 256; v++) begin
      logic [8:0] c;
      logic [7:0] vv;
      vv = 8'(v);
      c = {vv[0], vv};
      rgb5 = {vv[4:0], 5'(v + 11), ~vv[4:0]};
      rgb8 = {vv ^ 8'h3C, ~vv, vv};
      sample(c, vv[1], vv[2], 1'b1, 1'b1, e3(c[2:0]), e3(c[5:3]), e3(c[8:6]),
             1'b0, 0, 0, 1'b0);
    end

    do_reset();
    run_frame(5, 1'b0, 1'b0, -1, -1, H_ACT, 0, 0);
    run_frame(V_ACT, 1'b1, 1'b0, -1, 7, H_ACT, V_ACT, 1);
    run_frame(V_ACT, 1'b1, 1'b1, -1, -1, H_ACT, V_ACT, 2);
    run_frame(V_ACT, 1'b0, 1'b0, 10, -1, H_ACT, 0, 0);
    run_frame(V_ACT, 1'b1, 1'b1, -1, -1, H_ACT, V_ACT, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
